// File: rtl/async_fifo_pkg.sv
// -----------------------------------------------------------------------------
// async_fifo_pkg
// Shared pointer-code helpers for the asynchronous FIFO read side.
//   bin2gray : binary -> reflected Gray code
//   gray2bin : reflected Gray code -> binary (XOR prefix from the MSB down)
// Both work on a PTR_MAX_W-wide word. Any narrower pointer is handled by
// zero-extending the operand and truncating the result back to its own width.
// The zero upper bits do not change either conversion.
// -----------------------------------------------------------------------------
package async_fifo_pkg;

  localparam int PTR_MAX_W = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_word_t;

  function automatic ptr_word_t bin2gray(input ptr_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_word_t gray2bin(input ptr_word_t g);
    ptr_word_t b;
    b = g;
    for (int i = 1; i < PTR_MAX_W; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_w2r.sv
// -----------------------------------------------------------------------------
// sync_w2r
// Multi-flop synchronizer that brings the write-domain Gray pointer into rclk.
// Ports:
//   rclk     : read-domain clock
//   rrst_n   : asynchronous active-low reset, clears every stage
//   wptr     : Gray write pointer, asynchronous to rclk
//   rq2_wptr : output of the last synchronizer stage
// SYNC_STAGES must be at least 2.
// -----------------------------------------------------------------------------
module sync_w2r #(
  parameter int ADDRSIZE    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic [ADDRSIZE:0] wptr,
  output logic [ADDRSIZE:0] rq2_wptr
);

  logic [SYNC_STAGES-1:0][ADDRSIZE:0] r_sync;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], wptr};
    end
  end

  assign rq2_wptr = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/rptr_empty_sync.sv
// -----------------------------------------------------------------------------
// rptr_empty_sync
// Read-side pointer and status logic of an asynchronous FIFO.
// Ports:
//   rclk    : read-domain clock (only clock of this block)
//   rrst_n  : asynchronous active-low reset
//   rinc    : read request, ignored while rempty is high
//   wptr    : Gray write pointer from the write domain (asynchronous)
//   rempty  : registered FIFO-empty flag
//   arempty : registered almost-empty flag (occupancy <= AREMPTYSIZE)
//   raddr   : binary memory read address, taken straight from rbin
//   rptr    : registered Gray read pointer for the write domain
//   rlevel  : registered read-side occupancy estimate
// Build option:
//   ASYNC_FIFO_RLEVEL_EN defined   -> rlevel carries the occupancy estimate
//   ASYNC_FIFO_RLEVEL_EN undefined -> rlevel is tied to 0, no level register
// -----------------------------------------------------------------------------
module rptr_empty_sync
  import async_fifo_pkg::*;
#(
  parameter int ADDRSIZE    = 4,
  parameter int AREMPTYSIZE = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   wptr,
  output logic                rempty,
  output logic                arempty,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE:0]   rlevel
);

  localparam int PW = ADDRSIZE + 1;

  logic [ADDRSIZE:0] w_rq2_wptr;
  logic [ADDRSIZE:0] w_rq2_wbin;
  logic [ADDRSIZE:0] w_rbinnext;
  logic [ADDRSIZE:0] w_rgraynext;
  logic [ADDRSIZE:0] w_rdist;
  logic              w_rd_en;

  logic [ADDRSIZE:0] r_rbin;
  logic [ADDRSIZE:0] r_rptr;
  logic              r_rempty;
  logic              r_arempty;

  sync_w2r #(
    .ADDRSIZE    (ADDRSIZE),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_w2r (
    .rclk     (rclk),
    .rrst_n   (rrst_n),
    .wptr     (wptr),
    .rq2_wptr (w_rq2_wptr)
  );

  // Reads are only accepted while not empty, so the pointer can never
  // overtake the synchronized write pointer.
  assign w_rd_en     = rinc & ~r_rempty;
  assign w_rbinnext  = r_rbin + {{ADDRSIZE{1'b0}}, w_rd_en};
  assign w_rgraynext = PW'(bin2gray(ptr_word_t'(w_rbinnext)));
  assign w_rq2_wbin  = PW'(gray2bin(ptr_word_t'(w_rq2_wptr)));

  // Modular distance from the post-read pointer to the synchronized write
  // pointer; the natural PW-bit wrap of the subtraction gives the modulo.
  assign w_rdist = w_rq2_wbin - w_rbinnext;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_rbin    <= '0;
      r_rptr    <= '0;
      r_rempty  <= 1'b1;
      r_arempty <= 1'b1;
    end else begin
      r_rbin    <= w_rbinnext;
      r_rptr    <= w_rgraynext;
      r_rempty  <= (w_rgraynext == w_rq2_wptr);
      r_arempty <= (ptr_word_t'(w_rdist) <= ptr_word_t'(AREMPTYSIZE));
    end
  end

`ifdef ASYNC_FIFO_RLEVEL_EN
  logic [ADDRSIZE:0] r_rlevel;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_rlevel <= '0;
    end else begin
      r_rlevel <= w_rdist;
    end
  end

  assign rlevel = r_rlevel;
`else
  assign rlevel = '0;
`endif

  assign rempty  = r_rempty;
  assign arempty = r_arempty;
  assign raddr   = r_rbin[ADDRSIZE-1:0];
  assign rptr    = r_rptr;

endmodule

// File: tb/tb_rptr_empty_sync.sv
`timescale 1ns/1ps
module tb_rptr_empty_sync;

  localparam int ADDRSIZE    = 4;
  localparam int AREMPTYSIZE = 1;
  localparam int SYNC_STAGES = 2;
  localparam int PW          = ADDRSIZE + 1;
  localparam int MOD         = 1 << PW;
  localparam int DEPTH       = 1 << ADDRSIZE;
`ifdef ASYNC_FIFO_RLEVEL_EN
  localparam bit LVL_EN = 1'b1;
`else
  localparam bit LVL_EN = 1'b0;
`endif

  logic              rclk   = 1'b0;
  logic              rrst_n = 1'b0;
  logic              rinc   = 1'b0;
  logic [ADDRSIZE:0] wptr   = '0;
  logic              rempty;
  logic              arempty;
  logic [ADDRSIZE-1:0] raddr;
  logic [ADDRSIZE:0] rptr;
  logic [ADDRSIZE:0] rlevel;

  int total = 0;
  int bad   = 0;

  // Reference model: plain word counts. The read side compares against the
  // write count it sampled SYNC_STAGES edges ago.
  int m_wcnt;
  int m_rcnt;
  int m_pipe [SYNC_STAGES];
  int m_level;
  bit m_empty;
  bit m_arempty;

  rptr_empty_sync #(
    .ADDRSIZE    (ADDRSIZE),
    .AREMPTYSIZE (AREMPTYSIZE),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .rinc    (rinc),
    .wptr    (wptr),
    .rempty  (rempty),
    .arempty (arempty),
    .raddr   (raddr),
    .rptr    (rptr),
    .rlevel  (rlevel)
  );

  always #5 rclk = ~rclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [ADDRSIZE:0] gray(input int v);
    logic [ADDRSIZE:0] b;
    b = PW'(v % MOD);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [ADDRSIZE:0] exp_lvl(input int lvl);
    return LVL_EN ? PW'(lvl) : '0;
  endfunction

  task automatic model_reset();
    m_wcnt = 0;
    m_rcnt = 0;
    for (int i = 0; i < SYNC_STAGES; i++) m_pipe[i] = 0;
    m_level   = 0;
    m_empty   = 1'b1;
    m_arempty = 1'b1;
  endtask

  task automatic write_words(input int n);
    m_wcnt = m_wcnt + n;
    wptr   = gray(m_wcnt);
  endtask

  // Called at a falling edge with inputs already set; returns at the next one.
  task automatic step();
    int seen;
    seen = m_pipe[SYNC_STAGES-1];
    @(posedge rclk);
    if (rinc && !m_empty) m_rcnt++;
    m_level   = ((seen - m_rcnt) % MOD + MOD) % MOD;
    m_empty   = (m_level == 0);
    m_arempty = (m_level <= AREMPTYSIZE);
    for (int i = SYNC_STAGES-1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
    m_pipe[0] = m_wcnt;
    @(negedge rclk);
  endtask

  task automatic apply_reset();
    @(negedge rclk);
    rrst_n = 1'b0;
    rinc   = 1'b0;
    wptr   = '0;
    model_reset();
    @(negedge rclk);
    rrst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    write_words(3);
    repeat (3) step();
    rinc = 1'b1;
    step();
    rinc = 1'b0;
    total++;
    if (rptr !== gray(1)) begin
      bad++;
      $display("FAIL reset_pre_rptr: got %b want %b", rptr, gray(1));
    end
    #2;
    rrst_n = 1'b0;
    #1;
    total++;
    if (rempty !== 1'b1) begin bad++; $display("FAIL reset_rempty: got %b want 1", rempty); end
    total++;
    if (arempty !== 1'b1) begin bad++; $display("FAIL reset_arempty: got %b want 1", arempty); end
    total++;
    if (rptr !== '0) begin bad++; $display("FAIL reset_rptr: got %b want 0", rptr); end
    total++;
    if (raddr !== '0) begin bad++; $display("FAIL reset_raddr: got %0d want 0", raddr); end
    total++;
    if (rlevel !== '0) begin bad++; $display("FAIL reset_rlevel: got %0d want 0", rlevel); end
    wptr = '0;
    model_reset();
    @(negedge rclk);
    rrst_n = 1'b1;
    rinc   = 1'b1;
    step();
    rinc = 1'b0;
    total++;
    if (rptr !== '0 || rempty !== 1'b1) begin
      bad++;
      $display("FAIL reset_rinc_when_empty: rptr=%b rempty=%b want 0/1", rptr, rempty);
    end
  endtask

  task automatic test_single_write();
    apply_reset();
    write_words(1);
    for (int e = 1; e <= 3; e++) begin
      step();
      total++;
      if (rempty !== (e < 3)) begin
        bad++;
        $display("FAIL single_rempty_edge%0d: got %b want %b", e, rempty, (e < 3));
      end
    end
    total++;
    if (rlevel !== exp_lvl(1)) begin
      bad++;
      $display("FAIL single_rlevel: got %0d want %0d", rlevel, exp_lvl(1));
    end
    total++;
    if (arempty !== 1'b1) begin bad++; $display("FAIL single_arempty: got %b want 1", arempty); end
  endtask

  task automatic test_drain();
    apply_reset();
    write_words(5);
    total++;
    if (wptr !== 5'b00111) begin bad++; $display("FAIL drain_wptr_code: got %b want 00111", wptr); end
    repeat (3) step();
    rinc = 1'b1;
    for (int k = 0; k < 6; k++) begin
      total++;
      if (raddr !== ADDRSIZE'(k < 5 ? k : 5)) begin
        bad++;
        $display("FAIL drain_raddr%0d: got %0d want %0d", k, raddr, (k < 5 ? k : 5));
      end
      step();
      if (k == 4) begin
        total++;
        if (rempty !== 1'b1 || rptr !== 5'b00111) begin
          bad++;
          $display("FAIL drain_last: rempty=%b rptr=%b want 1/00111", rempty, rptr);
        end
      end
    end
    rinc = 1'b0;
    total++;
    if (rptr !== 5'b00111 || raddr !== 4'd5) begin
      bad++;
      $display("FAIL drain_ignored_rinc: rptr=%b raddr=%0d want 00111/5", rptr, raddr);
    end
  endtask

  task automatic test_almost_empty();
    logic [2:0] lv [3];
    lv[0] = 3'd3; lv[1] = 3'd2; lv[2] = 3'd1;
    apply_reset();
    write_words(3);
    repeat (3) step();
    for (int r = 0; r < 3; r++) begin
      if (r > 0) begin
        rinc = 1'b1;
        step();
        rinc = 1'b0;
      end
      total++;
      if (rlevel !== exp_lvl(int'(lv[r]))) begin
        bad++;
        $display("FAIL ae_rlevel%0d: got %0d want %0d", r, rlevel, exp_lvl(int'(lv[r])));
      end
      total++;
      if (arempty !== (r == 2)) begin
        bad++;
        $display("FAIL ae_arempty%0d: got %b want %b", r, arempty, (r == 2));
      end
      total++;
      if (rempty !== 1'b0) begin bad++; $display("FAIL ae_rempty%0d: got %b want 0", r, rempty); end
    end
  endtask

  task automatic test_wrap();
    int wraps;
    int toggles;
    int prev_addr;
    logic prev_msb;
    bit done;
    apply_reset();
    wraps     = 0;
    toggles   = 0;
    prev_addr = 0;
    prev_msb  = 1'b0;
    done      = 1'b0;
    rinc      = 1'b1;
    for (int cyc = 0; cyc < 120 && !done; cyc++) begin
      if (m_wcnt < 40) write_words(1);
      step();
      total++;
      if (rptr !== gray(m_rcnt) || raddr !== ADDRSIZE'(m_rcnt % DEPTH) || rempty !== m_empty) begin
        bad++;
        $display("FAIL wrap_cyc%0d: rptr=%b raddr=%0d rempty=%b want %b/%0d/%b",
                 cyc, rptr, raddr, rempty, gray(m_rcnt), m_rcnt % DEPTH, m_empty);
      end
      if (prev_addr == DEPTH-1 && int'(raddr) == 0) wraps++;
      if (rptr[ADDRSIZE] !== prev_msb) toggles++;
      prev_addr = int'(raddr);
      prev_msb  = rptr[ADDRSIZE];
      if (m_wcnt == 40 && m_rcnt == 40) done = 1'b1;
    end
    rinc = 1'b0;
    total++;
    if (!done) begin bad++; $display("FAIL wrap_timeout: reads=%0d want 40", m_rcnt); end
    total++;
    if (wraps != 2) begin bad++; $display("FAIL wrap_raddr_wraps: got %0d want 2", wraps); end
    total++;
    if (toggles != 2) begin bad++; $display("FAIL wrap_msb_toggles: got %0d want 2", toggles); end
    total++;
    if (rempty !== 1'b1 || rptr !== gray(40)) begin
      bad++;
      $display("FAIL wrap_end: rempty=%b rptr=%b want 1/%b", rempty, rptr, gray(40));
    end
  endtask

  task automatic test_random();
    int wr_bias;
    int rd_bias;
    apply_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      wr_bias = (cyc / 150) % 2 == 0 ? 3 : 1;
      rd_bias = (cyc / 150) % 2 == 0 ? 1 : 3;
      if ($urandom_range(3, 0) < wr_bias && (m_wcnt - m_rcnt) < DEPTH) write_words(1);
      rinc = ($urandom_range(3, 0) < rd_bias);
      step();
      total++;
      if (rempty !== m_empty || arempty !== m_arempty) begin
        bad++;
        $display("FAIL rand_flags_cyc%0d: rempty=%b arempty=%b want %b/%b",
                 cyc, rempty, arempty, m_empty, m_arempty);
      end
      total++;
      if (rptr !== gray(m_rcnt) || raddr !== ADDRSIZE'(m_rcnt % DEPTH)) begin
        bad++;
        $display("FAIL rand_ptr_cyc%0d: rptr=%b raddr=%0d want %b/%0d",
                 cyc, rptr, raddr, gray(m_rcnt), m_rcnt % DEPTH);
      end
      total++;
      if (rlevel !== exp_lvl(m_level)) begin
        bad++;
        $display("FAIL rand_rlevel_cyc%0d: got %0d want %0d", cyc, rlevel, exp_lvl(m_level));
      end
    end
    rinc = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_write();
    test_drain();
    test_almost_empty();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rptr_empty_sync.md
RPTR_EMPTY_SYNC -- requirements
Module: rptr_empty_sync

Interface
REQ-001 SHALL have parameter ADDRSIZE, default 4, FIFO address width (depth 2^ADDRSIZE).
REQ-002 SHALL have parameter AREMPTYSIZE, default 1, almost-empty threshold in words.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, minimum 2, number of write-pointer synchronizer flops.
REQ-004 rclk  input  1  read-domain clock; the block's only clock.
REQ-005 rrst_n  input  1  reset, asynchronous, active-low.
REQ-006 rinc  input  1  read request.
REQ-007 wptr  input  ADDRSIZE+1  Gray write pointer from the write domain, asynchronous to rclk.
REQ-008 rempty  output  1  FIFO empty, registered.
REQ-009 arempty  output  1  FIFO almost empty, registered.
REQ-010 raddr  output  ADDRSIZE  binary memory read address.
REQ-011 rptr  output  ADDRSIZE+1  Gray read pointer, registered, for transfer to the write domain.
REQ-012 rlevel  output  ADDRSIZE+1  read-side occupancy estimate, registered.

Function
REQ-013 SHALL pass wptr through a SYNC_STAGES-deep flop chain clocked by rclk; the last stage is rq2_wptr.
REQ-014 SHALL hold binary read counter rbin (ADDRSIZE+1 bits); rbinnext = rbin + (rinc & ~rempty), modulo 2^(ADDRSIZE+1).
REQ-015 SHALL compute rgraynext = (rbinnext >> 1) ^ rbinnext, and register rbin <= rbinnext and rptr <= rgraynext on every rclk edge.
REQ-016 raddr SHALL equal rbin[ADDRSIZE-1:0], with no extra register.
REQ-017 rempty SHALL register (rgraynext == rq2_wptr).
REQ-018 SHALL convert rq2_wptr to binary rq2_wbin using the Gray-to-binary XOR prefix.
REQ-019 arempty SHALL register ((rq2_wbin - rbinnext) mod 2^(ADDRSIZE+1)) <= AREMPTYSIZE.
REQ-020 rinc while rempty=1 SHALL be ignored: no pointer change and no underflow.
REQ-021 Latency: a wptr change SHALL clear rempty on the (SYNC_STAGES+1)th rclk edge after it is stable at the input.
REQ-022 Latency: the read that consumes the last word SHALL set rempty on the same edge that rptr advances.
REQ-023 Wrap: raddr SHALL wrap from 2^ADDRSIZE-1 to 0; rptr MSB SHALL toggle on each address wrap; rbin SHALL wrap from all-ones to 0.
REQ-024 Simultaneous write arrival and last-word read: rempty SHALL reflect the comparison of rgraynext against the rq2_wptr value sampled at that edge.

Reset
REQ-025 rrst_n low SHALL immediately, without a clock edge, force rbin=0, rptr=0, raddr=0, all synchronizer flops=0, rempty=1, arempty=1, rlevel=0.
REQ-026 Reset asserted mid-operation SHALL discard all pointer state; there is no partial recovery.
REQ-027 Deassertion SHALL be sampled only by rclk; the first rinc is honoured on the first edge after release, subject to rempty.

Configuration
REQ-028 Macro ASYNC_FIFO_RLEVEL_EN defined: rlevel SHALL register (rq2_wbin - rbinnext) mod 2^(ADDRSIZE+1) every rclk edge.
REQ-029 Macro ASYNC_FIFO_RLEVEL_EN undefined: rlevel SHALL be constant 0 and its subtractor/register SHALL be absent; REQ-019 logic remains present.

Structure
REQ-030 Package async_fifo_pkg SHALL hold bin2gray and gray2bin functions, parameterized by width.
REQ-031 The synchronizer chain SHALL be sub-module sync_w2r (parameters ADDRSIZE, SYNC_STAGES; ports rclk, rrst_n, wptr, rq2_wptr).
REQ-032 No other sub-modules; all read-domain logic SHALL reside in rptr_empty_sync.

Verification (ADDRSIZE=4, AREMPTYSIZE=1, SYNC_STAGES=2, macro defined)
REQ-033 Reset: drop rrst_n mid-clock -> rempty=1, arempty=1, rptr=0, raddr=0, rlevel=0 before the next rclk edge.
REQ-034 Single write: wptr 0->1 -> rempty falls on the 3rd rclk edge; rlevel=1; arempty stays 1.
REQ-035 Drain: wptr=gray(5)=5'b00111, rinc high 6 cycles -> raddr 0,1,2,3,4; rempty rises with rptr=5'b00111; 6th rinc ignored and rptr unchanged.
REQ-036 Almost empty: wptr=gray(3), no reads -> arempty=0 with rlevel=3; one read -> rlevel=2, arempty=0; second read -> rlevel=1, arempty=1.
REQ-037 Wrap: 40 write/read pairs -> raddr 15->0 twice; rptr MSB toggles at rbin 16 and again at rbin 32 (rbin wraps to 0); rempty correct throughout.
REQ-038 Macro undefined: repeat REQ-036 stimulus -> rlevel=0 throughout; arempty sequence unchanged.
